// File: rtl/alu_seq_pkg.sv
// Shared types, flag bit positions and op-decoding helpers for the nibble-serial ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        ADC = 3'd1,
        SUB = 3'd2,
        SBC = 3'd3,
        AND = 3'd4,
        XOR = 3'd5,
        OR  = 3'd6,
        CP  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_C  = 0;
    localparam int FLAG_N  = 1;
    localparam int FLAG_PV = 2;
    localparam int FLAG_X  = 3;
    localparam int FLAG_H  = 4;
    localparam int FLAG_Y  = 5;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_S  = 7;

    function automatic logic op_is_sub(input op_t op);
        return (op == SUB) || (op == SBC) || (op == CP);
    endfunction

    function automatic logic op_is_logic(input op_t op);
        return (op == AND) || (op == XOR) || (op == OR);
    endfunction

    // Carry fed into nibble 0; subtraction is a + ~b + 1, so SBC borrows by dropping that 1.
    function automatic logic first_carry(input op_t op, input logic cf);
        logic c;
        c = 1'b0;
        case (op)
            ADC:     c = cf;
            SUB, CP: c = 1'b1;
            SBC:     c = ~cf;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    function automatic logic even_parity(input logic [7:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/alu_nibble_core.sv
// Combinational 4-bit ALU slice: binary or decimal-corrected add/subtract, or a bitwise logic op.
module alu_nibble_core
    import alu_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  op_t        op,
    input  logic       sub,
    input  logic       bcd,
    output logic [3:0] nibble,
    output logic       cout
);

    logic [3:0] b_eff;
    logic [4:0] sum;

    assign b_eff = sub ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};

    // Decimal correction: adds fold 10..19 back into 0..9 with a carry; subtract borrows drop 6.
    always_comb begin
        nibble = sum[3:0];
        cout   = sum[4];
        case (op)
            AND: begin
                nibble = a & b;
                cout   = 1'b0;
            end
            XOR: begin
                nibble = a ^ b;
                cout   = 1'b0;
            end
            OR: begin
                nibble = a | b;
                cout   = 1'b0;
            end
            default: begin
                if (bcd && !sub && (sum[4] || (sum[3:0] > 4'd9))) begin
                    nibble = sum[3:0] + 4'd6;
                    cout   = 1'b1;
                end else if (bcd && sub && !sum[4]) begin
                    nibble = sum[3:0] - 4'd6;
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial WIDTH-bit ALU sequencer producing a result and a Z80-format flag byte.
// Decimal mode is built only when ALU_SEQ_BCD_EN is defined; otherwise the bcd input is ignored.
module alu_nibble_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  op_t              op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cf_in,
    input  logic             bcd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       flags
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-5:0] sum_acc;
    op_t              op_q;
    logic             sub_q;
    logic             logic_q;
    logic             carry_q;
    logic             bcd_q;
    logic             h_q;
    logic [1:0]       yx_q;

    logic             bcd_sel;
    logic [3:0]       nib;
    logic             nib_cout;
    logic [WIDTH-1:0] full_sum;
    logic [WIDTH-1:0] res_next;
    logic [7:0]       flags_next;
    logic             b_msb;
    logic             overflow;

`ifdef ALU_SEQ_BCD_EN
    assign bcd_sel = bcd;
`else
    assign bcd_sel = bcd & 1'b0;
`endif

    alu_nibble_core u_core (
        .a      (a_sh[3:0]),
        .b      (b_sh[3:0]),
        .cin    (carry_q),
        .op     (op_q),
        .sub    (sub_q),
        .bcd    (bcd_sel & bcd_q),
        .nibble (nib),
        .cout   (nib_cout)
    );

    // On the last nibble the slice inputs hold the operand msbs, so overflow is judged there.
    assign full_sum = {nib, sum_acc};
    assign b_msb    = sub_q ? ~b_sh[3] : b_sh[3];
    assign overflow = (a_sh[3] == b_msb) && (nib[3] != a_sh[3]);

    always_comb begin
        res_next            = (op_q == CP) ? op1_q : full_sum;
        flags_next          = '0;
        flags_next[FLAG_S]  = full_sum[WIDTH-1];
        flags_next[FLAG_Z]  = (full_sum == '0);
        flags_next[FLAG_Y]  = (op_q == CP) ? yx_q[1] : full_sum[5];
        flags_next[FLAG_X]  = (op_q == CP) ? yx_q[0] : full_sum[3];
        flags_next[FLAG_H]  = logic_q ? (op_q == AND) : (h_q ^ sub_q);
        flags_next[FLAG_PV] = (logic_q || bcd_q) ? even_parity(full_sum[7:0]) : overflow;
        flags_next[FLAG_N]  = sub_q;
        flags_next[FLAG_C]  = logic_q ? 1'b0 : (nib_cout ^ sub_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            flags   <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            op1_q   <= '0;
            sum_acc <= '0;
            op_q    <= ADD;
            sub_q   <= 1'b0;
            logic_q <= 1'b0;
            carry_q <= 1'b0;
            bcd_q   <= 1'b0;
            h_q     <= 1'b0;
            yx_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    sum_acc <= full_sum[WIDTH-1:4];
                    carry_q <= nib_cout;
                    if (idx == '0) begin
                        h_q <= nib_cout;
                    end
                    if (idx == LAST_IDX) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= res_next;
                        flags  <= flags_next;
                        idx    <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                // IDLE and DONE both accept a new request.
                default: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        idx     <= '0;
                        a_sh    <= op1;
                        b_sh    <= op2;
                        op1_q   <= op1;
                        sum_acc <= '0;
                        op_q    <= op;
                        sub_q   <= op_is_sub(op);
                        logic_q <= op_is_logic(op);
                        carry_q <= first_carry(op, cf_in);
                        bcd_q   <= bcd_sel;
                        yx_q    <= {op2[5], op2[3]};
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed-vector bench for alu_nibble_seq at WIDTH=8 and WIDTH=16; decimal expectations follow ALU_SEQ_BCD_EN.
module tb_alu_nibble_seq;
    import alu_seq_pkg::*;

    typedef struct {
        op_t        op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cf;
        logic       bcd;
        logic [7:0] res;
        logic [7:0] flg;
    } vec8_t;

    typedef struct {
        op_t         op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cf;
        logic [15:0] res;
        logic [7:0]  flg;
    } vec16_t;

`ifdef ALU_SEQ_BCD_EN
    localparam logic [7:0] BCD_ADD_RES = 8'h47, BCD_ADD_FLG = 8'h14;
    localparam logic [7:0] BCD_SUB_RES = 8'h09, BCD_SUB_FLG = 8'h1E;
    localparam logic [7:0] BCD_CRY_RES = 8'h00, BCD_CRY_FLG = 8'h55;
`else
    localparam logic [7:0] BCD_ADD_RES = 8'h41, BCD_ADD_FLG = 8'h10;
    localparam logic [7:0] BCD_SUB_RES = 8'h0F, BCD_SUB_FLG = 8'h1A;
    localparam logic [7:0] BCD_CRY_RES = 8'h9A, BCD_CRY_FLG = 8'h88;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start8, cf8, bcd8, busy8, done8;
    op_t         op8;
    logic [7:0]  a8, b8, res8, flags8;
    logic        start16, cf16, bcd16, busy16, done16;
    op_t         op16;
    logic [15:0] a16, b16, res16;
    logic [7:0]  flags16;

    int checks   = 0;
    int failures = 0;

    vec8_t  vecs8[18];
    vec16_t vecs16[4];

    alu_nibble_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .op1(a8), .op2(b8),
        .cf_in(cf8), .bcd(bcd8), .busy(busy8), .done(done8), .result(res8), .flags(flags8)
    );

    alu_nibble_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .op1(a16), .op2(b16),
        .cf_in(cf16), .bcd(bcd16), .busy(busy16), .done(done16), .result(res16), .flags(flags16)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input string name, input vec8_t v);
        int cycles;
        @(negedge clk);
        op8 = v.op; a8 = v.a; b8 = v.b; cf8 = v.cf; bcd8 = v.bcd; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        checkOutput({name, " busy"}, 32'(busy8), 32'd1);
        cycles = 0;
        do begin
            @(posedge clk);
            #1 cycles++;
        end while (!done8 && cycles < 20);
        checkOutput({name, " latency"}, 32'(cycles), 32'd2);
        checkOutput({name, " result"}, 32'(res8), 32'(v.res));
        checkOutput({name, " flags"}, 32'(flags8), 32'(v.flg));
    endtask

    task automatic applyStimulus16(input string name, input vec16_t v);
        int cycles;
        @(negedge clk);
        op16 = v.op; a16 = v.a; b16 = v.b; cf16 = v.cf; bcd16 = 1'b0; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        cycles = 0;
        do begin
            @(posedge clk);
            #1 cycles++;
        end while (!done16 && cycles < 20);
        checkOutput({name, " latency"}, 32'(cycles), 32'd4);
        checkOutput({name, " result"}, 32'(res16), 32'(v.res));
        checkOutput({name, " flags"}, 32'(flags16), 32'(v.flg));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;

        vecs8[0]  = '{ADD, 8'h8C, 8'h6D, 1'b0, 1'b0, 8'hF9, 8'hB8};
        vecs8[1]  = '{SUB, 8'h10, 8'h01, 1'b0, 1'b0, 8'h0F, 8'h1A};
        vecs8[2]  = '{XOR, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h44};
        vecs8[3]  = '{AND, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'h0F, 8'h1C};
        vecs8[4]  = '{ADC, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 8'h94};
        vecs8[5]  = '{SBC, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'hBB};
        vecs8[6]  = '{CP,  8'h42, 8'h42, 1'b0, 1'b0, 8'h42, 8'h42};
        vecs8[7]  = '{CP,  8'h10, 8'h20, 1'b0, 1'b0, 8'h10, 8'hA3};
        vecs8[8]  = '{OR,  8'h80, 8'h01, 1'b0, 1'b0, 8'h81, 8'h84};
        vecs8[9]  = '{SUB, 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 8'h3E};
        vecs8[10] = '{ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h51};
        vecs8[11] = '{ADD, 8'h01, 8'h01, 1'b1, 1'b0, 8'h02, 8'h00};
        vecs8[12] = '{XOR, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 8'hAC};
        vecs8[13] = '{SBC, 8'h10, 8'h01, 1'b0, 1'b0, 8'h0F, 8'h1A};
        vecs8[14] = '{ADD, 8'h19, 8'h28, 1'b0, 1'b1, BCD_ADD_RES, BCD_ADD_FLG};
        vecs8[15] = '{SUB, 8'h10, 8'h01, 1'b0, 1'b1, BCD_SUB_RES, BCD_SUB_FLG};
        vecs8[16] = '{ADD, 8'h99, 8'h01, 1'b0, 1'b1, BCD_CRY_RES, BCD_CRY_FLG};
        vecs8[17] = '{AND, 8'hFF, 8'h0F, 1'b0, 1'b1, 8'h0F, 8'h1C};

        vecs16[0] = '{ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 8'h51};
        vecs16[1] = '{ADC, 16'h1234, 16'h4321, 1'b1, 16'h5556, 8'h00};
        vecs16[2] = '{SBC, 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 8'h3E};
        vecs16[3] = '{SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 8'hBB};

        reset = 1'b1;
        start8 = 1'b0; op8 = ADD; a8 = '0; b8 = '0; cf8 = 1'b0; bcd8 = 1'b0;
        start16 = 1'b0; op16 = ADD; a16 = '0; b16 = '0; cf16 = 1'b0; bcd16 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy8), 32'd0);
        checkOutput("reset done", 32'(done8), 32'd0);
        checkOutput("reset result", 32'(res8), 32'd0);
        checkOutput("reset flags", 32'(flags8), 32'd0);
        checkOutput("reset result16", 32'(res16), 32'd0);
        reset = 1'b0;

        // Back-to-back vectors restart in the DONE cycle; every third one starts from IDLE.
        for (int i = 0; i < 18; i++) begin
            if (i % 3 == 0) repeat (2) @(posedge clk);
            applyStimulus($sformatf("v8[%0d]", i), vecs8[i]);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus16($sformatf("v16[%0d]", i), vecs16[i]);
        end

        // Second start and operand changes while busy must not disturb the running op.
        repeat (2) @(posedge clk);
        @(negedge clk);
        op8 = ADD; a8 = 8'h01; b8 = 8'h01; cf8 = 1'b0; bcd8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 op8 = SUB; a8 = 8'hFF; b8 = 8'hFF;
        checkOutput("ignore busy", 32'(busy8), 32'd1);
        @(posedge clk);
        #1 start8 = 1'b0;
        checkOutput("ignore early done", 32'(done8), 32'd0);
        @(posedge clk);
        #1 checkOutput("ignore done", 32'(done8), 32'd1);
        checkOutput("ignore result", 32'(res8), 32'h02);
        checkOutput("ignore flags", 32'(flags8), 32'h00);
        pulses = 0;
        repeat (4) begin
            @(posedge clk);
            #1 if (done8 || busy8) pulses++;
        end
        checkOutput("ignore no restart", 32'(pulses), 32'd0);

        // Reset in the middle of a 16-bit op aborts it without a done pulse.
        @(negedge clk);
        op16 = ADD; a16 = 16'hFFFF; b16 = 16'h0001; cf16 = 1'b0; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1 checkOutput("abort busy", 32'(busy16), 32'd0);
        checkOutput("abort result", 32'(res16), 32'd0);
        checkOutput("abort flags", 32'(flags16), 32'd0);
        checkOutput("abort done", 32'(done16), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (done16) pulses++;
        end
        checkOutput("abort no done", 32'(pulses), 32'd0);
        checkOutput("abort idle", 32'(busy16), 32'd0);
        applyStimulus16("after abort", vecs16[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
